uart_rx_fifo_param: RTL and testbench

- Parametrised, oversampling UART receiver for the UART clock domain, with a small show-ahead receive FIFO on its output.
- Successor to the fixed 8-bit receiver in SYS_TOP. Adds:
  - generic data width
  - runtime-selectable prescale, parity and stop-bit count
  - majority-vote sampling
  - buffered frames with overrun detection
- The consumer pops words with a one-cycle read strobe. Error events are reported as one-cycle pulses.

---
 rtl/uart_rx_fifo_param.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver with 2-of-3 majority-vote bit sampling and a show-ahead receive FIFO.
// Frame format (prescale, parity, stop bits) is captured at each detected start edge.
module uart_rx_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PTW = AW + 1;
    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);
    localparam logic [BCW-1:0]        BIT_ZERO = {BCW{1'b0}};
    localparam logic [BCW-1:0]        BIT_ONE  = BCW'(1);
    localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [PTW-1:0]        PTR_ONE  = PTW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_PUSH   = 3'd5
    } state_t;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    samp0_q, samp0_d, samp1_q, samp1_d;
    logic                    par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic                    rx_prev_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    empty_q, empty_d, full_q, full_d;

    logic [PRESCALE_W-1:0]   half_s, samp_lo_s, samp_hi_s, last_s;
    logic                    vote_s, at_vote_s, at_end_s;
    logic                    push_s, do_wr_s, do_rd_s;

    assign half_s    = {1'b0, presc_q[PRESCALE_W-1:1]};
    assign samp_lo_s = half_s - CNT_ONE;
    assign samp_hi_s = half_s + CNT_ONE;
    assign last_s    = presc_q - CNT_ONE;
    assign at_vote_s = (edge_cnt_q == samp_hi_s);
    assign at_end_s  = (edge_cnt_q == last_s);
    assign vote_s    = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);

    // Receiver next-state, bit timing and frame assembly
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q + CNT_ONE;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        samp0_d    = (edge_cnt_q == samp_lo_s) ? RX_IN : samp0_q;
        samp1_d    = (edge_cnt_q == half_s)    ? RX_IN : samp1_q;
        case (state_q)
            S_IDLE: begin
                edge_cnt_d = CNT_ZERO;
                // A start needs a high-to-low transition, so a line held low after reset is ignored
                if (rx_prev_q && !RX_IN) begin
                    state_d    = S_START;
                    edge_cnt_d = CNT_ONE;
                    bit_cnt_d  = BIT_ZERO;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    presc_d    = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (at_vote_s && vote_s) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = CNT_ZERO;
                end else if (at_end_s) begin
                    state_d    = S_DATA;
                    edge_cnt_d = CNT_ZERO;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                shift_d = at_vote_s ? {vote_s, shift_q[DATA_WIDTH-1:1]} : shift_q;
                if (at_end_s) begin
                    edge_cnt_d = CNT_ZERO;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = BIT_ZERO;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                par_bad_d = at_vote_s ? (vote_s != expected_parity(shift_q, par_typ_q)) : par_bad_q;
                if (at_end_s) begin
                    state_d    = S_STOP;
                    edge_cnt_d = CNT_ZERO;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (at_vote_s) begin
                    stop_bad_d = stop_bad_q | ~vote_s;
                    if (!stop2_q || (bit_cnt_q != BIT_ZERO)) begin
                        state_d    = S_PUSH;
                        edge_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (at_end_s) begin
                    edge_cnt_d = CNT_ZERO;
                    bit_cnt_d  = bit_cnt_q + BIT_ONE;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_PUSH: begin
                state_d    = S_IDLE;
                edge_cnt_d = CNT_ZERO;
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= CNT_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            shift_q    <= {DATA_WIDTH{1'b0}};
            samp0_q    <= 1'b0;
            samp1_q    <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            presc_q    <= CNT_ZERO;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            rx_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            rx_prev_q  <= RX_IN;
        end
    end

    assign push_s  = (state_q == S_PUSH) && !stop_bad_q && !par_bad_q;
    assign do_rd_s = rd_en && !empty_q;
    assign do_wr_s = push_s && (!full_q || rd_en);

    assign framing_error = (state_q == S_PUSH) && stop_bad_q;
    assign parity_error  = (state_q == S_PUSH) && !stop_bad_q && par_bad_q;
    assign overrun       = push_s && full_q && !rd_en;

    // FIFO pointer, flag and show-ahead head computation
    always_comb begin
        wr_ptr_d = do_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        if (empty_d) begin
            rd_data_d = rd_data_q;
        end else if (do_wr_s && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = shift_q;
        end else begin
            rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // FIFO storage and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q  <= {PTW{1'b0}};
            rd_ptr_q  <= {PTW{1'b0}};
            rd_data_q <= {DATA_WIDTH{1'b0}};
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            if (do_wr_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: serial frames are driven bit by bit, expected words
// go into a scoreboard queue and are compared as the FIFO is popped.
module tb_uart_rx_fifo_param;
    localparam int DW    = 8;
    localparam int PW    = 6;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty, full, parity_error, framing_error, overrun;

    int checks = 0;
    int failures = 0;
    int n_par = 0, n_frm = 0, n_ovr = 0;
    int e_par = 0, e_frm = 0, e_ovr = 0;
    logic [DW-1:0] exp_q[$];

    uart_rx_fifo_param #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full),
        .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse bookkeeping: error pulses are counted and must never overlap
    always @(negedge CLK) begin
        if (RST) begin
            n_par += int'(parity_error);
            n_frm += int'(framing_error);
            n_ovr += int'(overrun);
            check("pulse_exclusive",
                  32'((int'(parity_error) + int'(framing_error) + int'(overrun)) <= 1), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        RX_IN = v;
        step(p);
    endtask

    // Drives a frame and returns in the PUSH cycle (just after the final stop-bit vote)
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pe, input logic pt,
                              input logic s2, input logic bad_par, input logic bad_stop,
                              input int flip_bit);
        Prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
        drive_bit(1'b0, p);
        Prescale = 6'd30;
        PAR_EN   = ~pe;
        PAR_TYP  = ~pt;
        STOP2    = ~s2;
        for (int i = 0; i < DW; i++) begin
            if (i == flip_bit) begin
                RX_IN = d[i];
                step(p / 2);
                RX_IN = ~d[i];
                step(1);
                RX_IN = d[i];
                step(p / 2 - 1);
            end else begin
                drive_bit(d[i], p);
            end
        end
        if (pe) drive_bit((^d) ^ pt ^ bad_par, p);
        if (s2) drive_bit(1'b1, p);
        RX_IN = ~bad_stop;
        step(p / 2 + 2);
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] exp;
        check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_empty"}, 32'(empty), 32'd0);
            check({tag, "_data"}, 32'(rd_data), 32'(exp));
        end
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_npar"}, 32'(n_par), 32'(e_par));
        check({tag, "_nfrm"}, 32'(n_frm), 32'(e_frm));
        check({tag, "_novr"}, 32'(n_ovr), 32'(e_ovr));
    endtask

    initial begin
        logic [DW-1:0] base;
        logic [DW-1:0] dmid;

        step(3);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pulses", 32'({parity_error, framing_error, overrun}), 32'd0);
        RST = 1'b1;
        step(4);

        // Single good frame, even parity, exact write latency
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("t1_push_pulses", 32'({parity_error, framing_error, overrun}), 32'd0);
        check("t1_push_empty", 32'(empty), 32'd1);
        step(1);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_data", 32'(rd_data), 32'hA5);
        step(8);
        pop_check("t1_pop");
        check("t1_empty_after", 32'(empty), 32'd1);

        // Parity error, odd parity, P=16
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        e_par++;
        check("t2_perr", 32'(parity_error), 32'd1);
        check("t2_ferr", 32'(framing_error), 32'd0);
        step(1);
        check("t2_perr_off", 32'(parity_error), 32'd0);
        check("t2_empty", 32'(empty), 32'd1);
        step(16);
        check_counts("t2");

        // Framing error on second stop bit, then a good frame
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        e_frm++;
        check("t3_ferr", 32'(framing_error), 32'd1);
        RX_IN = 1'b1;
        step(1);
        check("t3_empty", 32'(empty), 32'd1);
        step(16);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(8);
        pop_check("t3_pop");

        // Bad parity and bad stop together: only the framing pulse
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        e_frm++;
        check("t3p_ferr", 32'(framing_error), 32'd1);
        check("t3p_perr", 32'(parity_error), 32'd0);
        RX_IN = 1'b1;
        step(16);
        check_counts("t3");

        // Start glitch, then a frame with one bad sample in bit 3
        Prescale = 6'd8;
        RX_IN = 1'b0;
        step(2);
        RX_IN = 1'b1;
        step(40);
        check("t4_glitch_empty", 32'(empty), 32'd1);
        check_counts("t4g");
        exp_q.push_back(8'h5B);
        send_frame(8'h5B, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        step(8);
        pop_check("t4_vote_pop");

        // Overrun and pointer wrap, two rounds
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 8'h01 : 8'h11;
            for (int k = 0; k < DEPTH; k++) begin
                exp_q.push_back(base + DW'(k));
                send_frame(base + DW'(k), 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
                step(4);
                check("t5_full", 32'(full), 32'(k == DEPTH - 1));
            end
            send_frame(base + 8'd4, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            e_ovr++;
            check("t5_overrun", 32'(overrun), 32'd1);
            step(1);
            check("t5_overrun_off", 32'(overrun), 32'd0);
            check("t5_full_kept", 32'(full), 32'd1);
            step(4);
            for (int k = 0; k < DEPTH; k++) pop_check("t5_pop");
            check("t5_empty", 32'(empty), 32'd1);
            check("t5_notfull", 32'(full), 32'd0);
            check("t5_hold", 32'(rd_data), 32'(base + 8'd3));
        end
        check_counts("t5");

        // Reset during data bit 4 with one word buffered; line held low after release
        exp_q.push_back(8'h77);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(8);
        check("t6_pre_empty", 32'(empty), 32'd0);
        dmid = 8'hC6;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(dmid[i], 8);
        RX_IN = dmid[4];
        step(2);
        RX_IN = 1'b0;
        RST = 1'b0;
        #2;
        exp_q.delete();
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_data", 32'(rd_data), 32'd0);
        step(2);
        RST = 1'b1;
        step(24);
        RX_IN = 1'b1;
        step(100);
        check("t6_low_line_empty", 32'(empty), 32'd1);
        check_counts("t6");
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(8);
        pop_check("t6_pop");

        // Frame arriving while full with a simultaneous pop is accepted
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(8'h21 + DW'(k));
            send_frame(8'h21 + DW'(k), 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            step(4);
        end
        check("t7_full", 32'(full), 32'd1);
        exp_q.push_back(8'h25);
        send_frame(8'h25, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        rd_en = 1'b1;
        #1;
        check("t7_no_overrun", 32'(overrun), 32'd0);
        check("t7_head", 32'(rd_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        step(1);
        rd_en = 1'b0;
        check("t7_full_kept", 32'(full), 32'd1);
        step(4);
        for (int k = 0; k < DEPTH; k++) pop_check("t7_pop");
        check("t7_empty", 32'(empty), 32'd1);

        // Pop while empty is ignored
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("t8_empty", 32'(empty), 32'd1);
        check("t8_full", 32'(full), 32'd0);
        check("t8_hold", 32'(rd_data), 32'h25);
        check_counts("t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
